obc_bitplane_sequencer: RTL and testbench
=========================================

Name: obc_bitplane_sequencer

Overview:
- Sequential front/back end for the OBC 16-point DFT ROM datapath.
- Accepts 16 parallel signed samples and emits them bit-serially, one bit-plane per cycle, LSB first. Drives the 16 address bits and the sign-cycle flag `m` into the OBC ROM accumulator.
- Takes the ROM accumulator's combinational sum back each cycle and shift-accumulates it into the final DFT output word.
- Returns the result through a valid/ready handshake.

Parameters:
- W, 8: sample width in bits, two's complement; also the number of bit-plane cycles per transform.
- ROM_W, 32: width of the ROM-sum return path `rom_in`, two's complement.
- ACC_W, ROM_W+W: accumulator and result width. Must be at least ROM_W+W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample block valid
- in_ready  out  1  block may be accepted this cycle
- in_data  in  16*W  sample i at bits [i*W +: W], i = 0..15
- xbits  out  16  current bit-plane; xbits[i] = bit `cnt` of sample i; drives x00..x015
- m  out  1  1 only on the sign-bit cycle (cnt == W-1)
- rom_in  in  ROM_W  combinational ROM sum for the xbits/m presented this cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  accumulated result
- busy  out  1  high in RUN or DONE
- offset_in  in  ROM_W  present only with OBC_INIT_OFFSET_EN

Behaviour:
- Reset (asynchronous, rst_n = 0) puts the block in this state:
  - state = IDLE; cnt = 0; acc = 0; all 16 sample shift registers = 0.
  - in_ready = 1; out_valid = 0; out_data = 0; xbits = 0; m = 0; busy = 0.
  - Reset asserted mid-RUN or mid-DONE aborts the transform; the partial result is discarded and no out_valid is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load the 16 samples into shift registers, set cnt = 0, set acc = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - xbits[i] = LSB of shift register i.
  - m = (cnt == W-1).
  - Each cycle: acc <= acc + (sign_extend(rom_in, ACC_W) << cnt); all shift registers shift right by 1; cnt <= cnt + 1.
  - When cnt == W-1, the final add is performed and the state goes to DONE. cnt wraps to 0.
  - Exactly W RUN cycles per transform.
- DONE:
  - out_valid = 1; out_data = acc, held stable while out_ready = 0.
  - xbits = 0; m = 0.
  - On out_ready: out_valid drops, or the block is back-to-back reloaded as described next.
  - in_ready = out_ready in DONE. If in_valid & out_ready both hold in the same cycle, the new block is loaded and the state goes directly to RUN, with no IDLE bubble.
  - Otherwise on out_ready, go to IDLE.
- xbits and m are 0 in IDLE and DONE.
- Latency: load edge at T, RUN cycles T+1..T+W, out_valid high from edge T+W.
- Throughput with out_ready tied high: one transform per W+1 cycles.
- Arithmetic:
  - Sign handling of the MSB plane is done by the ROM side via m; this block never negates.
  - All adds are modulo 2^ACC_W; no saturation.
- in_data and rom_in are ignored outside the cycles where they are sampled.

Optional Feature:
- Macro: OBC_INIT_OFFSET_EN.
- Defined: port offset_in exists. On each block load, acc is initialised to sign_extend(offset_in, ACC_W) instead of 0, which carries the OBC constant offset term. offset_in is sampled only on the load edge.
- Undefined: no offset_in port; acc is initialised to 0.

Test Plan:
- W = 8, all samples 0, bench drives rom_in = 1 every RUN cycle -> out_data = 255 after 8 RUN cycles; m high only on the 8th RUN cycle.
- Sample0 = 0x81, others 0 -> xbits = 16'h0001 on RUN cycles 0 and 7, 16'h0000 on cycles 1..6.
- rom_in = 32'hFFFFFFFF on cycle 7 only, 0 otherwise -> out_data = -128 sign-extended to ACC_W (40'hFFFFFFFF80).
- out_ready held low 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready 0. Then out_ready = 1 together with in_valid = 1 -> new load on that edge, RUN on the next cycle.
- rst_n pulsed low at RUN cycle 3 -> outputs immediately at their reset values; after release in_ready = 1 and no out_valid for the aborted block.
- OBC_INIT_OFFSET_EN defined, offset_in = 100, rom_in = 0 -> out_data = 100. With rom_in = 1 on every cycle -> out_data = 355.

Source files
------------

// File: rtl/obc_bitplane_sequencer.sv
// Bit-serial front/back end for the OBC 16-point DFT ROM datapath: emits sample bit-planes
// LSB first and shift-accumulates the returned ROM sums. Optional macro: OBC_INIT_OFFSET_EN.
module obc_bitplane_sequencer #(
  parameter int W     = 8,
  parameter int ROM_W = 32,
  parameter int ACC_W = ROM_W + W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*W-1:0]     in_data,
  output logic [15:0]         xbits,
  output logic                m,
  input  logic [ROM_W-1:0]    rom_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
`ifdef OBC_INIT_OFFSET_EN
  input  logic [ROM_W-1:0]    offset_in,
`endif
  output logic                busy
);

  // state | meaning
  // IDLE  | waiting for a sample block, in_ready high
  // RUN   | one bit-plane per cycle, W cycles, accumulating rom_in
  // DONE  | result held on out_data until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [W-1:0]     sr [16];
  logic [ACC_W-1:0] rom_ext;
  logic [ACC_W-1:0] init_val;
  logic             load;

  assign rom_ext = {{(ACC_W-ROM_W){rom_in[ROM_W-1]}}, rom_in};

`ifdef OBC_INIT_OFFSET_EN
  // The OBC constant offset term seeds the accumulator instead of costing an extra add cycle.
  assign init_val = {{(ACC_W-ROM_W){offset_in[ROM_W-1]}}, offset_in};
`else
  assign init_val = '0;
`endif

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign load      = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign busy      = (state != IDLE);
  assign m         = (state == RUN) && (cnt == CNT_LAST);

  always_comb begin
    xbits = '0;
    if (state == RUN) begin
      for (int i = 0; i < 16; i++) xbits[i] = sr[i][0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      for (int i = 0; i < 16; i++) sr[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            for (int i = 0; i < 16; i++) sr[i] <= in_data[i*W +: W];
            cnt   <= '0;
            acc   <= init_val;
            state <= RUN;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          // The MSB plane's sign is applied ROM-side via m, so every plane is a plain add.
          acc <= acc + (rom_ext << cnt);
          for (int i = 0; i < 16; i++) sr[i] <= sr[i] >> 1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obc_bitplane_sequencer.sv
// Self-checking bench for obc_bitplane_sequencer: a phase-level model checked every cycle,
// plus directed transforms with hand-computed results.
module tb_obc_bitplane_sequencer;
  localparam int W     = 8;
  localparam int ROM_W = 32;
  localparam int ACC_W = ROM_W + W;

  logic             clk = 0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [16*W-1:0]  in_data;
  logic [15:0]      xbits;
  logic             m;
  logic [ROM_W-1:0] rom_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;
`ifdef OBC_INIT_OFFSET_EN
  logic [ROM_W-1:0] offset_in;
`endif

  int errors = 0;
  int checks = 0;
  bit started = 0;

  obc_bitplane_sequencer #(.W(W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .xbits(xbits), .m(m), .rom_in(rom_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef OBC_INIT_OFFSET_EN
    .offset_in(offset_in),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase -1 = idle, 0..W-1 = bit-plane index being presented, W = result pending.
  int          ph = -1;
  logic [W-1:0] ms [16];
  logic [ROM_W-1:0] mrom [W];
  longint      moff = 0;
  logic [ACC_W-1:0] mres = '0;

  task automatic model_load();
    for (int i = 0; i < 16; i++) ms[i] = in_data[i*W +: W];
`ifdef OBC_INIT_OFFSET_EN
    moff = longint'($signed(offset_in));
`else
    moff = 0;
`endif
    ph = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = -1;
    end else if (ph == -1) begin
      if (in_valid) model_load();
    end else if (ph < W) begin
      mrom[ph] = rom_in;
      if (ph == W - 1) begin
        longint sum;
        sum = moff;
        for (int k = 0; k < W; k++) sum += longint'($signed(mrom[k])) * (longint'(1) << k);
        mres = sum[ACC_W-1:0];
        ph = W;
      end else begin
        ph++;
      end
    end else if (out_ready) begin
      if (in_valid) model_load();
      else ph = -1;
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      logic [15:0] ex;
      ex = '0;
      if (ph >= 0 && ph < W)
        for (int i = 0; i < 16; i++) ex[i] = ms[i][ph];
      chk("in_ready", in_ready, (ph == -1) ? 1 : (ph == W) ? out_ready : 0);
      chk("busy", busy, ph != -1);
      chk("out_valid", out_valid, ph == W);
      chk("m", m, ph == W - 1);
      chk("xbits", xbits, ex);
      if (ph == W) chk("out_data", out_data, mres);
    end
  end

  // Caller sits just after a rising edge; the next edge is the load edge.
  task automatic set_load(input logic [16*W-1:0] d);
    in_valid = 1;
    in_data  = d;
  endtask

  task automatic do_run(input logic [W*ROM_W-1:0] roms, input bit chk_x,
                        input logic [W*16-1:0] xexp);
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      in_valid = 0;
      rom_in   = roms[k*ROM_W +: ROM_W];
      @(negedge clk);
      chk("m_plane", m, k == W - 1);
      if (chk_x) chk("xbits_plane", xbits, xexp[k*16 +: 16]);
    end
    @(posedge clk); #1;
    rom_in = '0;
  endtask

  initial begin
    logic [W*ROM_W-1:0] roms;
    logic [ACC_W-1:0]   held;
    rst_n = 0; in_valid = 0; in_data = '0; rom_in = '0; out_ready = 1;
`ifdef OBC_INIT_OFFSET_EN
    offset_in = '0;
`endif
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_xbits", xbits, 0);
    chk("rst_m", m, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    started = 1;

    // All-zero samples, rom_in = 1 every plane: 1+2+...+128 = 255.
    set_load('0);
    roms = {W{32'd1}};
    do_run(roms, 0, '0);
    @(negedge clk);
    chk("sum_ones", out_data, 255);

    // Sample 0 = 0x81: plane 0 and plane 7 set.
    @(posedge clk); #1;
    set_load(128'h81);
    do_run('0, 1, {16'h0001, {6{16'h0000}}, 16'h0001});

    // Only the sign plane returns -1: -128.
    @(posedge clk); #1;
    set_load(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    roms = '0;
    roms[7*ROM_W +: ROM_W] = 32'hFFFF_FFFF;
    do_run(roms, 0, '0);
    @(negedge clk);
    chk("sign_plane", out_data, 40'hFF_FFFF_FF80);

    // Back-pressure in DONE for 5 cycles, then simultaneous accept and reload.
    @(posedge clk); #1;
    out_ready = 0;
    set_load({16{8'h5A}});
    roms = {W{32'd2}};
    do_run(roms, 0, '0);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_data", out_data, 510);
      chk("hold_stable", out_data, held);
      chk("hold_in_ready", in_ready, 0);
      if (c < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1;
    set_load({16{8'hC3}});
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_out_valid", out_valid, 0);
    chk("b2b_xbits", xbits, 16'hFFFF);
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      rom_in = 32'd3;
    end
    @(posedge clk); #1;
    rom_in = '0;
    @(negedge clk);
    chk("b2b_result", out_data, 3 * (255 - 1));

    // Reset in RUN cycle 3 aborts the transform.
    @(posedge clk); #1;
    set_load({16{8'hFF}});
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = 0;
      rom_in = 32'd7;
    end
    #2 rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_xbits", xbits, 0);
    chk("abort_m", m, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end

`ifdef OBC_INIT_OFFSET_EN
    @(posedge clk); #1;
    offset_in = 32'd100;
    set_load({16{8'h11}});
    @(posedge clk); #1;
    offset_in = '0;
    in_valid = 0;
    for (int k = 1; k < W; k++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    @(negedge clk);
    chk("offset_only", out_data, 100);
    @(posedge clk); #1;
    offset_in = 32'd100;
    set_load('0);
    do_run({W{32'd1}}, 0, '0);
    @(negedge clk);
    chk("offset_plus", out_data, 355);
`endif

    // Randomised handshakes and data, checked by the model every cycle.
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      rom_in    = $urandom;
`ifdef OBC_INIT_OFFSET_EN
      offset_in = $urandom;
`endif
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

endmodule
